// File: rtl/alu_pipe_md.sv
// rtl/alu_pipe_md.sv - registered ALU with iterative MUL/DIV unit and HI/LO registers
// Optional macro ALU_OVF_EN enables the registered signed add/sub overflow flag.
module alu_pipe_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [5:0]       alu_fun,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, op_b;
  logic             div_op, res_neg, rem_neg;

  logic             accept, is_md, is_div, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] alu_res, add_b, add_sum;
  logic [SHW-1:0]   sh;
  logic             cmp_bit;

  assign accept = in_valid && in_ready;
  assign is_md  = (mode == 2'b01) || (mode == 2'b10);
  assign is_div = (mode == 2'b10);
  assign sa     = sign & a[WIDTH-1];
  assign sb     = sign & b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;

  always_comb begin
    alu_res = '0;
    cmp_bit = 1'b0;
    add_b   = alu_fun[0] ? ~b : b;
    add_sum = a + add_b + {{(WIDTH-1){1'b0}}, alu_fun[0]};
    sh      = a[SHW-1:0];
    case (alu_fun[5:4])
      2'b00: alu_res = add_sum;
      2'b01: begin
        case (alu_fun[3:0])
          4'b1000: alu_res = a & b;
          4'b1110: alu_res = a | b;
          4'b0110: alu_res = a ^ b;
          4'b0001: alu_res = ~(a | b);
          4'b1010: alu_res = a;
          default: alu_res = '0;
        endcase
      end
      2'b10: begin
        case (alu_fun[1:0])
          2'b00:   alu_res = b << sh;
          2'b01:   alu_res = b >> sh;
          2'b11:   alu_res = WIDTH'($signed(b) >>> sh);
          default: alu_res = '0;
        endcase
      end
      default: begin
        case (alu_fun[3:1])
          3'b001:  cmp_bit = (a == b);
          3'b000:  cmp_bit = (a != b);
          3'b010:  cmp_bit = sign ? ($signed(a) < $signed(b)) : (a < b);
          3'b110:  cmp_bit = a[WIDTH-1] | (a == '0);
          3'b101:  cmp_bit = a[WIDTH-1];
          3'b111:  cmp_bit = ~a[WIDTH-1] & (a != '0);
          default: cmp_bit = 1'b0;
        endcase
        alu_res = {{(WIDTH-1){1'b0}}, cmp_bit};
      end
    endcase
  end

  // Shared accumulator: {acc_hi,acc_lo} is the product for MUL, {remainder,quotient} for DIV.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_b};
    div_bit   = ~div_diff[WIDTH];
    prod_fix  = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (div_op) begin
      fix_lo = res_neg ? -acc_lo : acc_lo;
      fix_hi = rem_neg ? -acc_hi : acc_hi;
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      op_b      <= '0;
      cnt       <= '0;
      div_op    <= 1'b0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_md) begin
              state    <= ITER;
              in_ready <= 1'b0;
              cnt      <= '0;
              div_op   <= is_div;
              // A zero divisor keeps the all-ones quotient the restoring loop produces.
              res_neg  <= (sa ^ sb) & ~(is_div & (b == '0));
              rem_neg  <= sa;
              acc_hi   <= '0;
              acc_lo   <= is_div ? mag_a : mag_b;
              op_b     <= is_div ? mag_b : mag_a;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_res;
              zero      <= (alu_res == '0);
            end
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (div_op) begin
            acc_hi <= div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_bit};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b1;
          hi        <= fix_hi;
          lo        <= fix_lo;
          result    <= fix_lo;
          zero      <= (fix_lo == '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_OVF_EN
  logic add_ovf;
  assign add_ovf = sign & (a[WIDTH-1] == add_b[WIDTH-1]) & (add_sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept && !is_md && state == IDLE) begin
      ovf <= (alu_fun[5:4] == 2'b00) & add_ovf;
    end else if (state == FIX) begin
      ovf <= 1'b0;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe_md.sv
// tb/tb_alu_pipe_md.sv - directed self-checking bench for alu_pipe_md (WIDTH=32)
module tb_alu_pipe_md;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  mode = 2'b00;
  logic [5:0]  alu_fun = 6'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [31:0] result, hi, lo;
  logic        zero, ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, lows, pulses;
  logic exp_ovf;

  alu_pipe_md #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .alu_fun(alu_fun), .sign(sign), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .hi(hi), .lo(lo),
    .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [5:0] f, input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    mode = 2'b00; alu_fun = f; sign = s; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic md(input logic [1:0] m, input logic s, input logic [31:0] x, input logic [31:0] y,
                    output int l, output int lw);
    @(negedge clk);
    mode = m; sign = s; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    l = 0; lw = 0;
    while (out_valid !== 1'b1 && l < 60) begin
      if (in_ready === 1'b0) lw++;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
`ifdef ALU_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    alu(6'b000001, 1'b0, 32'd5, 32'd7);
    check("sub_valid", out_valid, 1);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_zero", zero, 0);
    check("sub_ready", in_ready, 1);

    alu(6'b000000, 1'b0, 32'd5, 32'hFFFF_FFFB);
    check("add_zero_result", result, 0);
    check("add_zero_flag", zero, 1);

    alu(6'b100011, 1'b0, 32'd4, 32'h8000_0000);
    check("sra_result", result, 32'hF800_0000);
    alu(6'b100001, 1'b0, 32'd4, 32'h8000_0000);
    check("srl_result", result, 32'h0800_0000);
    alu(6'b011110, 1'b0, 32'h0000_00F0, 32'h0000_000F);
    check("or_result", result, 32'h0000_00FF);
    alu(6'b010001, 1'b0, 32'h0000_00F0, 32'h0000_000F);
    check("nor_result", result, 32'hFFFF_FF00);
    alu(6'b110101, 1'b0, 32'd1, 32'hFFFF_FFFF);
    check("ltu_result", result, 1);
    alu(6'b110101, 1'b1, 32'd1, 32'hFFFF_FFFF);
    check("lts_result", result, 0);
    alu(6'b111110, 1'b1, 32'd5, 32'd0);
    check("gtz_result", result, 1);

    alu(6'b000000, 1'b1, 32'h7FFF_FFFF, 32'd1);
    check("ovf_result", result, 32'h8000_0000);
    check("ovf_flag", ovf, exp_ovf);
    @(negedge clk);
    check("pulse_end", out_valid, 0);

    md(2'b01, 1'b1, 32'hFFFF_FFFD, 32'd7, lat, lows);
    check("mul_latency", lat + 1, 34);
    check("mul_ready_low", lows, 33);
    check("mul_ready_back", in_ready, 1);
    check("mul_hi", hi, 32'hFFFF_FFFF);
    check("mul_lo", lo, 32'hFFFF_FFEB);
    check("mul_result", result, 32'hFFFF_FFEB);
    check("mul_ovf", ovf, 0);
    @(negedge clk);
    check("mul_pulse_end", out_valid, 0);

    md(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, lows);
    check("div_latency", lat + 1, 34);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    md(2'b10, 1'b1, 32'd9, 32'd0, lat, lows);
    check("dbz_latency", lat + 1, 34);
    check("dbz_lo", lo, 32'hFFFF_FFFF);
    check("dbz_hi", hi, 32'd9);

    md(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, lows);
    check("minneg_lo", lo, 32'h8000_0000);
    check("minneg_hi", hi, 32'd0);

    md(2'b10, 1'b0, 32'd100, 32'd7, lat, lows);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    alu(6'b000000, 1'b0, 32'd1, 32'd2);
    check("alu_keeps_hi", hi, 32'd2);
    check("alu_keeps_lo", lo, 32'd14);

    @(negedge clk);
    mode = 2'b10; sign = 1'b1; a = 32'd50; b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_reset", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    check("no_pulse_after_reset", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
